// File: rtl/elevator_car_controller_if.sv
// Car controller bus: call requests and step clock in, car status out.
// The master side is the car environment; the slave side is the controller.
interface elevator_car_controller_if #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2
);
    logic [N_FLOORS-1:0] call_req;
    logic                step_clk;
    logic                move_en;
    logic [FLOOR_W-1:0]  current_floor;
    logic                dir_up;
    logic                door_open;
    logic [N_FLOORS-1:0] pending;

    modport master (
        output call_req, step_clk,
        input  move_en, current_floor, dir_up, door_open, pending
    );

    modport slave (
        input  call_req, step_clk,
        output move_en, current_floor, dir_up, door_open, pending
    );
endinterface

// File: rtl/elevator_car_controller.sv
// Car-motion FSM: latches floor calls, picks direction (SCAN), steps one floor
// or one door-dwell unit per synchronised step_clk rising edge.
module elevator_car_controller #(
    parameter int N_FLOORS   = 4,
    parameter int FLOOR_W    = 2,
    parameter int DOOR_STEPS = 3
) (
    input logic                      clk_50,
    input logic                      rst_n,
    elevator_car_controller_if.slave bus
);
    localparam int CNT_W = (DOOR_STEPS > 1) ? $clog2(DOOR_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOOR_STEPS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t              state_q, state_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic                dir_up_q, dir_up_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [N_FLOORS-1:0] req, clear_mask;
    logic                s1_q, s2_q, step_rise;
    logic                move_en_q, door_open_q;
    logic                any_above, any_below, ahead, behind;

    assign step_rise = s1_q & ~s2_q;
    // Fresh calls are visible in the same cycle so a call at the current floor opens the door next cycle.
    assign req       = pending_q | bus.call_req;

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_q) any_above = any_above | req[i];
            if (FLOOR_W'(i) < floor_q) any_below = any_below | req[i];
        end
        ahead  = dir_up_q ? any_above : any_below;
        behind = dir_up_q ? any_below : any_above;
    end

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        cnt_d      = cnt_q;
        clear_mask = '0;
        case (state_q)
            IDLE: begin
                if (req[floor_q]) begin
                    clear_mask[floor_q] = 1'b1;
                    state_d             = DOOR;
                    cnt_d               = '0;
                end else if (any_above || any_below) begin
                    state_d = MOVE;
                    if (!(any_above && any_below)) dir_up_d = any_above;
                end
            end
            MOVE: begin
                // Never step without a target ahead: this also keeps the floor in range at the ends.
                if (!ahead) begin
                    if (behind) dir_up_d = ~dir_up_q;
                    else        state_d  = IDLE;
                end else if (step_rise) begin
                    floor_d = dir_up_q ? floor_q + 1'b1 : floor_q - 1'b1;
                    if (req[floor_d]) begin
                        clear_mask[floor_d] = 1'b1;
                        state_d             = DOOR;
                        cnt_d               = '0;
                    end
                end
            end
            DOOR: begin
                clear_mask[floor_q] = 1'b1;
                if (step_rise) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (ahead) begin
                            state_d = MOVE;
                        end else if (behind) begin
                            dir_up_d = ~dir_up_q;
                            state_d  = MOVE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = req & ~clear_mask;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            dir_up_q    <= 1'b1;
            cnt_q       <= '0;
            pending_q   <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            move_en_q   <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            s1_q        <= bus.step_clk;
            s2_q        <= s1_q;
            move_en_q   <= (state_d != IDLE);
            door_open_q <= (state_d == DOOR);
        end
    end

    assign bus.move_en       = move_en_q;
    assign bus.door_open     = door_open_q;
    assign bus.current_floor = floor_q;
    assign bus.dir_up        = dir_up_q;
    assign bus.pending       = pending_q;
endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed and randomized checks of the car controller against a SCAN service-order model.
module tb_elevator_car_controller;
    localparam int NF = 4;
    localparam int FW = 2;
    localparam int DS = 3;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   idle_cycles = 0;
    int   m_floor;
    bit   m_dir;
    int   exp_q[$];
    int   got_q[$];

    elevator_car_controller_if #(.N_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_car_controller #(
        .N_FLOORS  (NF),
        .FLOOR_W   (FW),
        .DOOR_STEPS(DS)
    ) dut (
        .clk_50(clk_50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_50);
        #1;
        if (bus.move_en === 1'b0) idle_cycles++;
    endtask

    task automatic pulse();
        bus.step_clk = 1'b1;
        repeat (3) cyc();
        bus.step_clk = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic call(input logic [NF-1:0] mask);
        bus.call_req = mask;
        cyc();
        bus.call_req = '0;
    endtask

    // SCAN order from the model's floor/direction for a set of calls issued while idle.
    task automatic plan(input logic [NF-1:0] mask);
        logic [NF-1:0] m;
        int  f;
        bit  d, above, below;
        m = mask;
        f = m_floor;
        d = m_dir;
        exp_q = {};
        if (m[f]) begin
            exp_q.push_back(f);
            m[f] = 1'b0;
        end
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (m[i] && i > f) above = 1'b1;
            if (m[i] && i < f) below = 1'b1;
        end
        if (above || below) begin
            if (!(d ? above : below)) d = !d;
            for (int leg = 0; leg < 2; leg++) begin
                if (leg == 1) begin
                    if (!(d ? below : above)) break;
                    d = !d;
                end
                if (d) begin
                    for (int i = f + 1; i < NF; i++) if (m[i]) exp_q.push_back(i);
                end else begin
                    for (int i = f - 1; i >= 0; i--) if (m[i]) exp_q.push_back(i);
                end
            end
        end
        if (exp_q.size() > 0) m_floor = exp_q[exp_q.size()-1];
        m_dir = d;
    endtask

    task automatic run_until_idle(input string tag);
        int run;
        bit prev;
        got_q = {};
        run   = 0;
        prev  = 1'b0;
        if (bus.door_open === 1'b1) begin
            got_q.push_back(int'(bus.current_floor));
            run  = 1;
            prev = 1'b1;
        end
        for (int k = 0; k < 60 && bus.move_en === 1'b1; k++) begin
            pulse();
            if (bus.door_open === 1'b1) begin
                if (!prev) begin
                    got_q.push_back(int'(bus.current_floor));
                    run = 0;
                end
                run++;
                prev = 1'b1;
            end else begin
                if (prev) chk({tag, " door_len"}, run, DS);
                prev = 1'b0;
            end
            chk({tag, " in_range"}, 32'(bus.current_floor < FW'(NF - 1) || bus.current_floor == FW'(NF - 1)), 1);
        end
        chk({tag, " idle_timeout"}, bus.move_en, 0);
    endtask

    task automatic check_stops(input string tag);
        chk({tag, " n_stops"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, " stop"}, got_q[i], exp_q[i]);
    endtask

    initial begin
        logic [NF-1:0] mask;
        bus.call_req = '0;
        bus.step_clk = 1'b0;
        repeat (2) cyc();
        chk("rst move_en", bus.move_en, 0);
        chk("rst floor", bus.current_floor, 0);
        chk("rst dir_up", bus.dir_up, 1);
        chk("rst door", bus.door_open, 0);
        chk("rst pending", bus.pending, 0);
        @(negedge clk_50);
        rst_n = 1'b1;
        cyc();
        m_floor = 0;
        m_dir   = 1'b1;

        // Call at the current floor opens the door without moving.
        plan(4'b0001);
        call(4'b0001);
        chk("t3 door", bus.door_open, 1);
        chk("t3 floor", bus.current_floor, 0);
        chk("t3 pending", bus.pending, 0);
        run_until_idle("t3");
        check_stops("t3");

        // Travel 0 -> 3.
        plan(4'b1000);
        call(4'b1000);
        chk("t2 move_en", bus.move_en, 1);
        chk("t2 pending", bus.pending, 8);
        chk("t2 door0", bus.door_open, 0);
        for (int i = 1; i <= 3; i++) begin
            pulse();
            chk("t2 floor", bus.current_floor, i);
        end
        chk("t2 door", bus.door_open, 1);
        chk("t2 pending_clr", bus.pending, 0);
        repeat (2) begin
            pulse();
            chk("t2 dwell", bus.door_open, 1);
        end
        pulse();
        chk("t2 door_closed", bus.door_open, 0);
        chk("t2 idle", bus.move_en, 0);
        chk("t2 final_floor", bus.current_floor, 3);
        chk("t2 final_pending", bus.pending, 0);

        plan(4'b0001);
        call(4'b0001);
        run_until_idle("home");
        check_stops("home");
        chk("home dir", bus.dir_up, 0);

        // SCAN: 1 and 3 up, late call at 0 served on the way back.
        exp_q = {1, 3, 0};
        call(4'b1010);
        chk("t4 dir_up", bus.dir_up, 1);
        chk("t4 move_en", bus.move_en, 1);
        pulse();
        chk("t4 floor1", bus.current_floor, 1);
        chk("t4 door1", bus.door_open, 1);
        call(4'b0001);
        chk("t4 pending", bus.pending, 9);
        run_until_idle("t4");
        check_stops("t4");
        chk("t4 dir_down", bus.dir_up, 0);
        chk("t4 floor0", bus.current_floor, 0);
        m_floor = 0;
        m_dir   = 1'b0;

        // Step clock held low during MOVE.
        plan(4'b1000);
        call(4'b1000);
        repeat (20) cyc();
        chk("t5 frozen", bus.current_floor, 0);
        chk("t5 move_en", bus.move_en, 1);
        chk("t5 dir_up", bus.dir_up, 1);
        run_until_idle("t5");
        check_stops("t5");

        // Level call at floor 2 held while the car stops there.
        bus.call_req = 4'b0100;
        cyc();
        chk("t6 move_en", bus.move_en, 1);
        chk("t6 dir_down", bus.dir_up, 0);
        pulse();
        chk("t6 floor", bus.current_floor, 2);
        chk("t6 door", bus.door_open, 1);
        chk("t6 pending", bus.pending, 0);
        pulse();
        pulse();
        chk("t6 held_pending", bus.pending, 0);
        idle_cycles = 0;
        pulse();
        chk("t6 idle_gap", idle_cycles, 1);
        chk("t6 reopen", bus.door_open, 1);
        bus.call_req = '0;
        exp_q = {2};
        run_until_idle("t6");
        check_stops("t6");
        chk("t6 pending_end", bus.pending, 0);

        // Reset while moving away from floor 2.
        call(4'b0001);
        cyc();
        chk("t1 moving", bus.move_en, 1);
        chk("t1 at2", bus.current_floor, 2);
        chk("t1 pend", bus.pending, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1 floor", bus.current_floor, 0);
        chk("t1 move_en", bus.move_en, 0);
        chk("t1 dir_up", bus.dir_up, 1);
        chk("t1 door", bus.door_open, 0);
        chk("t1 pending", bus.pending, 0);
        @(negedge clk_50);
        rst_n = 1'b1;
        cyc();
        m_floor = 0;
        m_dir   = 1'b1;

        for (int r = 0; r < 30; r++) begin
            mask = NF'($urandom_range(1, (1 << NF) - 1));
            plan(mask);
            call(mask);
            run_until_idle("rnd");
            check_stops("rnd");
            chk("rnd floor", bus.current_floor, m_floor);
            chk("rnd dir", bus.dir_up, m_dir);
            chk("rnd pending", bus.pending, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
